// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - MIPS 5-stage pipeline stall/flush sequencer with dmem wait watchdog
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             error,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_next;
  logic             r_error;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_freeze;
  logic             w_load_use;

  // The MEM stage cannot advance while its access is outstanding.
  assign w_freeze   = mem_access && !dmem_ready && (r_state != S_ERROR);
  assign w_load_use = ex_MemRead && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    dmem_req     = mem_access && (r_state != S_ERROR);
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      dmem_req    = 1'b0;
    end else if ((r_state == S_ERROR) || w_freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_redirect) begin
      // Everything younger than EX is on the wrong path.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (w_freeze) begin
          w_state_next = S_MEM_WAIT;
          w_wait_next  = 8'd1;
        end
      end
      S_MEM_WAIT: begin
        if (w_freeze) begin
          w_wait_next = r_wait_cnt + 8'd1;
          if (w_wait_next == LP_MAX_WAIT) begin
            w_state_next = S_ERROR;
          end
        end else begin
          w_state_next = S_RUN;
          w_wait_next  = 8'd0;
        end
      end
      S_ERROR: begin
        w_state_next = S_ERROR;
      end
      default: begin
        w_state_next = S_RUN;
        w_wait_next  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 8'd0;
      r_error     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      r_error    <= r_error || (w_state_next == S_ERROR);
      if (!pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign error        = r_error;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random checks of pipeline_hazard_ctrl against a cycle model
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, id_jump;
  logic             ex_MemRead, ex_redirect, mem_access, dmem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic             exmem_write, memwb_bubble, dmem_req, error;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: sticky timeout, consecutive unready cycles, stall total.
  bit m_err;
  int m_waits;
  int m_stalls;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .error(error),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_MemRead = 1'b0; ex_redirect = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs are already applied; check combinational outputs mid-cycle, then advance model and clock.
  task automatic run_cycle();
    bit hazard, frozen;
    bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub, e_req;
    hazard = ex_MemRead && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    frozen = m_err || (mem_access && !dmem_ready);
    {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub, e_req} = 8'b1101_0100;
    if (!rst_n) begin
      {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub, e_req} = 8'b0;
    end else begin
      e_req = mem_access && !m_err;
      if (frozen) begin
        {e_pc, e_ifw, e_idw, e_exw} = 4'b0;
        e_bub = 1'b1;
      end else if (ex_redirect) begin
        e_iff = 1'b1; e_idf = 1'b1;
      end else if (hazard) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
      end else if (id_jump) begin
        e_iff = 1'b1;
      end
    end
    @(negedge clk);
    check("ctrl", {24'd0, pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                   exmem_write, memwb_bubble, dmem_req},
          {24'd0, e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub, e_req});
    check("error", {31'd0, error}, {31'd0, m_err});
    check("stall_cycles", {28'd0, stall_cycles}, m_stalls);
    if (!rst_n) begin
      m_err = 0; m_waits = 0; m_stalls = 0;
    end else begin
      if (!m_err && mem_access && !dmem_ready) begin
        m_waits++;
        if (m_waits == MAX_WAIT) m_err = 1;
      end else if (!m_err) begin
        m_waits = 0;
      end
      if (!e_pc && m_stalls < SAT) m_stalls++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    rst_n = 1'b0;
    repeat (cycles) run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_err = 0; m_waits = 0; m_stalls = 0;
    @(posedge clk);
    #1;
    do_reset(2);
    run_cycle();

    // load-use on rs, then the same pattern against $zero
    ex_MemRead = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1; mem_access = 0;
    run_cycle();
    idle_inputs(); run_cycle();
    check("lu_stall_count", {28'd0, stall_cycles}, 32'd1);
    ex_MemRead = 1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
    run_cycle();

    // three unready cycles then completion
    idle_inputs(); mem_access = 1;
    repeat (3) run_cycle();
    dmem_ready = 1; run_cycle();
    idle_inputs(); run_cycle();
    check("mem_wait_stall_count", {28'd0, stall_cycles}, 32'd4);

    // redirect beats jump and load-use
    ex_redirect = 1; id_jump = 1; ex_MemRead = 1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1;
    run_cycle();
    // load-use defers the jump to the next cycle
    ex_redirect = 0; run_cycle();
    ex_MemRead = 0; run_cycle();

    // watchdog: never ready -> timeout, persistent freeze, counter saturation
    idle_inputs(); mem_access = 1;
    repeat (24) run_cycle();
    check("timeout_error", {31'd0, error}, 32'd1);
    check("saturated", {28'd0, stall_cycles}, SAT);
    dmem_ready = 1; repeat (2) run_cycle();
    do_reset(1);
    check("error_cleared", {31'd0, error}, 32'd0);

    // reset during a memory wait
    idle_inputs(); mem_access = 1;
    repeat (2) run_cycle();
    do_reset(1);
    dmem_ready = 1; mem_access = 1; run_cycle();
    idle_inputs(); run_cycle();

    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom);
      id_uses_rt  = 1'($urandom);
      id_jump     = ($urandom_range(0, 3) == 0);
      ex_MemRead  = 1'($urandom);
      ex_redirect = ($urandom_range(0, 4) == 0);
      mem_access  = 1'($urandom);
      dmem_ready  = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipelined version of the MIPS datapath. Sits beside the main instruction decoder.
- Produces PC and pipeline-register write-enables and flushes for load-use stalls, branch/jump redirects and variable-latency data-memory waits.
- Owns the data-memory request handshake and a watchdog timeout.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MAX_WAIT, 16, max consecutive dmem wait cycles before ERROR (range 2..255)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_jump  in  1  j/jal decoded in ID (target known in ID)
ex_MemRead  in  1  EX instruction is lw/lb
ex_rt  in  5  destination rt of EX load
ex_redirect  in  1  EX resolved taken branch or jr/jalr
mem_access  in  1  MEM instruction has MemRead or MemWrite
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID cleared to nop
idex_write  out  1  ID/EX enable
idex_flush  out  1  ID/EX cleared to bubble
exmem_write  out  1  EX/MEM enable
memwb_bubble  out  1  MEM/WB loads bubble
dmem_req  out  1  data memory request
error  out  1  sticky dmem timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Internal wait_cnt is 8 bits.
- Reset (reset=0 at a clock edge): state=RUN, wait_cnt=0, error=0, stall_cycles=0.
- While reset=0, the combinational outputs are forced: all enables=0, flushes=0, memwb_bubble=0, dmem_req=0.
- Outputs are combinational from state and inputs. Default values: all *_write=1, flushes=0, memwb_bubble=0.
- dmem_req = mem_access while state!=ERROR. Held high until dmem_ready, because the MEM stage is frozen. dmem_ready without dmem_req is ignored.
- Mem freeze condition: mem_access=1 and dmem_ready=0 in RUN or MEM_WAIT.
  - Outputs: pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1. No flushes.
  - Mem freeze has highest priority and masks all other rules.
- RUN, no mem freeze; rules checked in priority order:
  1. ex_redirect: ifid_flush=1, idex_flush=1, pc_write=1. Any id_jump or load-use in the same cycle is ignored (wrong path).
  2. Load-use: ex_MemRead and ex_rt!=0 and ((id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt)).
     - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
     - A simultaneous id_jump is deferred: it stays in ID and is handled next cycle.
  3. id_jump: ifid_flush=1.
- RUN transitions: mem freeze -> MEM_WAIT with wait_cnt=1; otherwise stay in RUN.
- MEM_WAIT:
  - dmem_ready=0: freeze continues; wait_cnt+1. When wait_cnt==MAX_WAIT at the edge -> ERROR, error=1.
  - dmem_ready=1: the freeze releases and the RUN rules apply in the same cycle; -> RUN, wait_cnt=0.
  - Ready arriving in the same cycle the counter would hit MAX_WAIT wins: -> RUN, no error.
- ERROR: permanent freeze (all enables 0, memwb_bubble=1), dmem_req=0, error=1. Left only by reset.
- stall_cycles increments on every edge where pc_write=0 with reset=1; saturates at 2^CNT_W-1.
- Redirect cycles do not count. Load-use, freeze and ERROR cycles do.
- Reset mid-MEM_WAIT: the next cycle is RUN with all counters clear. The pending access is abandoned; the memory must tolerate dmem_req dropping.

Test Plan:
- lw $8 in EX (ex_MemRead=1, ex_rt=8), ID add uses rs=8, dmem_ready=1 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle all defaults; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- mem_access=1, dmem_ready low 3 cycles then high -> 3 cycles of freeze with memwb_bubble=1 and dmem_req=1; 4th cycle enables=1; state RUN; stall_cycles=3.
- MAX_WAIT=4, dmem_ready never rises -> error=1 after 4 wait edges; dmem_req=0; freeze persists 20 cycles; reset clears error.
- ex_redirect=1 with id_jump=1 and a load-use pattern -> ifid_flush=1, idex_flush=1, pc_write=1; stall_cycles unchanged.
- Load-use plus id_jump together -> cycle 1 stall (ifid_flush=0); cycle 2 with ex_MemRead=0 -> ifid_flush=1.
- CNT_W=4, 20 freeze cycles -> stall_cycles saturates at 15. Reset asserted mid-MEM_WAIT -> all outputs 0 during reset; RUN and counters 0 afterwards.
